// File: rtl/bpsk_correlator.sv
// BPSK/DBPSK correlator: multiplies samples by an external reference, integrates
// over SPS samples with symmetric saturation and hands out one decided bit per symbol.
module bpsk_correlator #(
    parameter int DATA_WIDTH  = 8,
    parameter int SPS         = 16,
    parameter int ACC_WIDTH   = 24,
    parameter int PHASE_WIDTH = $clog2(SPS)
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic [DATA_WIDTH-1:0]  sample,
    input  logic                   sample_valid,
    output logic                   sample_ready,
    output logic [PHASE_WIDTH-1:0] ref_phase,
    input  logic [DATA_WIDTH-1:0]  ref_amp,
    input  logic                   symbol_start,
    input  logic                   diff_mode,
    output logic                   bit_valid,
    input  logic                   bit_ready,
    output logic                   bit_out,
    output logic [ACC_WIDTH-1:0]   bit_metric,
    output logic                   overflow
);

    localparam logic [PHASE_WIDTH-1:0] LAST_PHASE  = PHASE_WIDTH'(SPS - 1);
    localparam logic [PHASE_WIDTH-1:0] START_PHASE = PHASE_WIDTH'(1);
    localparam logic signed [ACC_WIDTH:0] MAX_W = $signed({2'b00, {(ACC_WIDTH-1){1'b1}}});
    localparam logic signed [ACC_WIDTH:0] MIN_W = -MAX_W;

    logic [PHASE_WIDTH-1:0] phase_q, phase_d;
    logic [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic                   prev_d_q, prev_d_d;
    logic                   bit_valid_q, bit_valid_d;
    logic                   bit_out_q, bit_out_d;
    logic [ACC_WIDTH-1:0]   bit_metric_q, bit_metric_d;
    logic                   overflow_q, overflow_d;

    logic signed [2*DATA_WIDTH-1:0] product;
    logic signed [ACC_WIDTH-1:0]    prod_ext;
    logic signed [ACC_WIDTH-1:0]    acc_base;
    logic signed [ACC_WIDTH:0]      wide_sum;
    logic signed [ACC_WIDTH-1:0]    sat_sum;
    logic                           sat_hit;
    logic                           at_last;
    logic                           accept;
    logic                           complete;
    logic                           decision;

    assign at_last      = (phase_q == LAST_PHASE);
    assign sample_ready = !(at_last && bit_valid_q && !bit_ready);
    assign accept       = sample_valid && sample_ready;
    assign complete     = accept && at_last && !symbol_start;

    // Realign restarts the integration from the current product alone.
    always_comb begin
        product  = $signed(sample) * $signed(ref_amp);
        prod_ext = ACC_WIDTH'(product);
        acc_base = symbol_start ? '0 : $signed(acc_q);
        wide_sum = $signed({acc_base[ACC_WIDTH-1], acc_base}) +
                   $signed({prod_ext[ACC_WIDTH-1], prod_ext});
        sat_hit  = 1'b0;
        if (wide_sum > MAX_W) begin
            sat_sum = MAX_W[ACC_WIDTH-1:0];
            sat_hit = 1'b1;
        end else if (wide_sum < MIN_W) begin
            sat_sum = MIN_W[ACC_WIDTH-1:0];
            sat_hit = 1'b1;
        end else begin
            sat_sum = wide_sum[ACC_WIDTH-1:0];
        end
        decision = sat_sum[ACC_WIDTH-1];
    end

    always_comb begin
        phase_d      = phase_q;
        acc_d        = acc_q;
        prev_d_d     = prev_d_q;
        bit_valid_d  = bit_valid_q;
        bit_out_d    = bit_out_q;
        bit_metric_d = bit_metric_q;
        overflow_d   = overflow_q;

        if (accept) begin
            overflow_d = overflow_q | sat_hit;
            if (symbol_start) begin
                acc_d   = sat_sum;
                phase_d = START_PHASE;
            end else if (at_last) begin
                acc_d   = '0;
                phase_d = '0;
            end else begin
                acc_d   = sat_sum;
                phase_d = phase_q + PHASE_WIDTH'(1);
            end
        end

        // A new result may replace the old one in the same cycle it is taken.
        if (complete) begin
            bit_valid_d  = 1'b1;
            bit_out_d    = diff_mode ? (decision ^ prev_d_q) : decision;
            bit_metric_d = decision ? -sat_sum : sat_sum;
            prev_d_d     = decision;
        end else if (bit_valid_q && bit_ready) begin
            bit_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            phase_q      <= '0;
            acc_q        <= '0;
            prev_d_q     <= 1'b0;
            bit_valid_q  <= 1'b0;
            bit_out_q    <= 1'b0;
            bit_metric_q <= '0;
            overflow_q   <= 1'b0;
        end else begin
            phase_q      <= phase_d;
            acc_q        <= acc_d;
            prev_d_q     <= prev_d_d;
            bit_valid_q  <= bit_valid_d;
            bit_out_q    <= bit_out_d;
            bit_metric_q <= bit_metric_d;
            overflow_q   <= overflow_d;
        end
    end

    assign ref_phase  = phase_q;
    assign bit_valid  = bit_valid_q;
    assign bit_out    = bit_out_q;
    assign bit_metric = bit_metric_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_bpsk_correlator.sv
// Directed bench for bpsk_correlator: a 24-bit accumulator instance for the main
// function and a 16-bit instance for saturation.
module tb_bpsk_correlator;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    logic [7:0]  sample = '0;
    logic        sample_valid = 1'b0;
    logic        sample_ready;
    logic [1:0]  ref_phase;
    logic [7:0]  ref_amp = 8'd100;
    logic        symbol_start = 1'b0;
    logic        diff_mode = 1'b0;
    logic        bit_valid;
    logic        bit_ready = 1'b1;
    logic        bit_out;
    logic [23:0] bit_metric;
    logic        overflow;

    logic [7:0]  s2_sample = '0;
    logic        s2_valid = 1'b0;
    logic        s2_ready;
    logic [1:0]  s2_phase;
    logic [7:0]  s2_ref = '0;
    logic        s2_start = 1'b0;
    logic        s2_diff = 1'b0;
    logic        s2_bit_valid;
    logic        s2_bit_ready = 1'b1;
    logic        s2_bit_out;
    logic [15:0] s2_metric;
    logic        s2_overflow;

    int checks = 0;
    int failures = 0;

    bpsk_correlator #(.DATA_WIDTH(8), .SPS(4), .ACC_WIDTH(24)) dut (
        .clock(clock), .reset_n(reset_n), .sample(sample), .sample_valid(sample_valid),
        .sample_ready(sample_ready), .ref_phase(ref_phase), .ref_amp(ref_amp),
        .symbol_start(symbol_start), .diff_mode(diff_mode), .bit_valid(bit_valid),
        .bit_ready(bit_ready), .bit_out(bit_out), .bit_metric(bit_metric), .overflow(overflow)
    );

    bpsk_correlator #(.DATA_WIDTH(8), .SPS(4), .ACC_WIDTH(16)) dut_sat (
        .clock(clock), .reset_n(reset_n), .sample(s2_sample), .sample_valid(s2_valid),
        .sample_ready(s2_ready), .ref_phase(s2_phase), .ref_amp(s2_ref),
        .symbol_start(s2_start), .diff_mode(s2_diff), .bit_valid(s2_bit_valid),
        .bit_ready(s2_bit_ready), .bit_out(s2_bit_out), .bit_metric(s2_metric),
        .overflow(s2_overflow)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
    endtask

    // Present one sample and wait (bounded) until it is accepted.
    task automatic send(input int s, input logic start);
        int n;
        sample       = 8'(s);
        sample_valid = 1'b1;
        symbol_start = start;
        n = 0;
        while (!sample_ready && n < 50) begin
            step();
            n++;
        end
        if (!sample_ready) chk("send_timeout", 32'(sample_ready), 32'd1);
        step();
        sample_valid = 1'b0;
        symbol_start = 1'b0;
    endtask

    task automatic send_symbol(input int s);
        for (int i = 0; i < 4; i++) send(s, 1'b0);
    endtask

    logic [1:0] diff_exp [4] = '{2'd0, 2'd1, 2'd1, 2'd0};  // 0 = positive symbol
    logic       diff_bits [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

    initial begin
        do_reset();
        chk("rst_bit_valid", 32'(bit_valid), 32'd0);
        chk("rst_bit_out", 32'(bit_out), 32'd0);
        chk("rst_metric", 32'(bit_metric), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_ready", 32'(sample_ready), 32'd1);
        chk("rst_phase", 32'(ref_phase), 32'd0);

        // Positive symbol, consumer always ready
        send(50, 1'b0);
        send(50, 1'b0);
        chk("pos_mid_phase", 32'(ref_phase), 32'd2);
        chk("pos_mid_no_bit", 32'(bit_valid), 32'd0);
        send(50, 1'b0);
        send(50, 1'b0);
        chk("pos_valid", 32'(bit_valid), 32'd1);
        chk("pos_bit", 32'(bit_out), 32'd0);
        chk("pos_metric", 32'(bit_metric), 32'd20000);
        chk("pos_overflow", 32'(overflow), 32'd0);
        chk("pos_phase_wrap", 32'(ref_phase), 32'd0);
        step();
        chk("pos_valid_drop", 32'(bit_valid), 32'd0);

        send_symbol(-50);
        chk("neg_valid", 32'(bit_valid), 32'd1);
        chk("neg_bit", 32'(bit_out), 32'd1);
        chk("neg_metric", 32'(bit_metric), 32'd20000);

        // Differential decoding from a clean previous decision
        do_reset();
        diff_mode = 1'b1;
        for (int k = 0; k < 4; k++) begin
            send_symbol(diff_exp[k] == 2'd0 ? 10 : -10);
            chk($sformatf("diff_valid_%0d", k), 32'(bit_valid), 32'd1);
            chk($sformatf("diff_bit_%0d", k), 32'(bit_out), 32'(diff_bits[k]));
            chk($sformatf("diff_metric_%0d", k), 32'(bit_metric), 32'd4000);
        end
        diff_mode = 1'b0;
        step();

        // Back-pressure across two symbols
        bit_ready = 1'b0;
        send_symbol(20);
        chk("bp_first_valid", 32'(bit_valid), 32'd1);
        for (int i = 0; i < 3; i++) send(-30, 1'b0);
        chk("bp_ready_low", 32'(sample_ready), 32'd0);
        chk("bp_phase", 32'(ref_phase), 32'd3);
        sample = 8'(-30);
        sample_valid = 1'b1;
        step();
        step();
        chk("bp_still_blocked", 32'(sample_ready), 32'd0);
        chk("bp_hold_valid", 32'(bit_valid), 32'd1);
        chk("bp_hold_bit", 32'(bit_out), 32'd0);
        chk("bp_hold_metric", 32'(bit_metric), 32'd8000);
        bit_ready = 1'b1;
        #1;
        chk("bp_ready_release", 32'(sample_ready), 32'd1);
        step();
        sample_valid = 1'b0;
        chk("bp_second_valid", 32'(bit_valid), 32'd1);
        chk("bp_second_bit", 32'(bit_out), 32'd1);
        chk("bp_second_metric", 32'(bit_metric), 32'd12000);
        step();
        chk("bp_drain", 32'(bit_valid), 32'd0);

        // Start without accept is ignored
        send(7, 1'b0);
        symbol_start = 1'b1;
        step();
        symbol_start = 1'b0;
        chk("start_no_accept", 32'(ref_phase), 32'd1);
        send(7, 1'b0);
        send(7, 1'b0);
        send(7, 1'b0);
        chk("start_ignored_bit", 32'(bit_metric), 32'd2800);
        step();

        // Realign on the third sample of a symbol
        send(40, 1'b0);
        send(40, 1'b0);
        send(-25, 1'b1);
        chk("realign_phase", 32'(ref_phase), 32'd1);
        chk("realign_no_bit", 32'(bit_valid), 32'd0);
        send(-25, 1'b0);
        send(-25, 1'b0);
        chk("realign_no_bit_yet", 32'(bit_valid), 32'd0);
        send(-25, 1'b0);
        chk("realign_valid", 32'(bit_valid), 32'd1);
        chk("realign_bit", 32'(bit_out), 32'd1);
        chk("realign_metric", 32'(bit_metric), 32'd10000);
        step();

        // Realign on the last phase: no result emitted
        for (int i = 0; i < 3; i++) send(10, 1'b0);
        send(10, 1'b1);
        chk("last_start_no_bit", 32'(bit_valid), 32'd0);
        chk("last_start_phase", 32'(ref_phase), 32'd1);
        for (int i = 0; i < 3; i++) send(-10, 1'b0);
        chk("last_start_valid", 32'(bit_valid), 32'd1);
        chk("last_start_bit", 32'(bit_out), 32'd1);
        chk("last_start_metric", 32'(bit_metric), 32'd2000);
        step();

        // Reset with a pending bit and a partial sum
        bit_ready = 1'b0;
        send_symbol(30);
        send(-60, 1'b0);
        do_reset();
        chk("rst2_valid", 32'(bit_valid), 32'd0);
        chk("rst2_phase", 32'(ref_phase), 32'd0);
        chk("rst2_metric", 32'(bit_metric), 32'd0);
        bit_ready = 1'b1;
        send_symbol(5);
        chk("rst2_clean_metric", 32'(bit_metric), 32'd2000);
        chk("rst2_clean_bit", 32'(bit_out), 32'd0);
        step();

        // Saturation on the 16-bit instance
        s2_sample = 8'h80;
        s2_ref    = 8'h80;
        s2_valid  = 1'b1;
        for (int i = 0; i < 4; i++) step();
        s2_valid = 1'b0;
        chk("sat_valid", 32'(s2_bit_valid), 32'd1);
        chk("sat_metric", 32'(s2_metric), 32'd32767);
        chk("sat_bit", 32'(s2_bit_out), 32'd0);
        chk("sat_overflow", 32'(s2_overflow), 32'd1);
        step();
        step();
        chk("sat_overflow_sticky", 32'(s2_overflow), 32'd1);
        chk("main_no_overflow", 32'(overflow), 32'd0);
        do_reset();
        chk("sat_overflow_cleared", 32'(s2_overflow), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
